// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
//   state_e   : arbiter FSM state (zero-fill sweep, normal traffic)
//   port_id_t : requester index
//   PORT0/1   : requester index constants
package sram_arb_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request per port
//   advance    : an op was accepted this cycle; move the pointer
//   gnt[1:0]   : one-hot grant, or zero when nothing is requested
// The pointer names the port that wins a tie. After an accepted op it moves
// to the port that did not win, so a lone requester cannot starve the other.
module sram_rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    port_id_t ptr_q, ptr_d;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr_q == PORT0) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = gnt[1] ? PORT0 : PORT1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= PORT0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between two requesters.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/ready/we/addr/wdata_{0,1} : request handshake per port; ready is
//                           a combinational grant, accept = valid && ready
//   rsp_valid/rdata_{0,1} : read response, one-cycle pulse, 2 edges after accept
//   mem_we/re/addr/wdata  : SRAM controls, driven combinationally from the grant
//   mem_rdata             : SRAM registered read data (1 cycle after mem_re)
//   init_done             : high once the arbiter accepts traffic
// With INIT_CLEAR set, every word is zero-filled after reset before any
// request is granted.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned AW         = 10,
    parameter int unsigned DW         = 8,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          req_valid_0,
    output logic          req_ready_0,
    input  logic          req_we_0,
    input  logic [AW-1:0] req_addr_0,
    input  logic [DW-1:0] req_wdata_0,
    output logic          rsp_valid_0,
    output logic [DW-1:0] rsp_rdata_0,

    input  logic          req_valid_1,
    output logic          req_ready_1,
    input  logic          req_we_1,
    input  logic [AW-1:0] req_addr_1,
    input  logic [DW-1:0] req_wdata_1,
    output logic          rsp_valid_1,
    output logic [DW-1:0] rsp_rdata_1,

    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          init_done
);

    localparam state_e StReset = INIT_CLEAR ? ST_INIT : ST_RUN;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic [1:0]    arb_req;
    logic [1:0]    gnt;
    logic          accept;

    logic          rd_pend_q, rd_pend_d;
    port_id_t      rd_port_q, rd_port_d;
    logic          rsp_valid_0_q, rsp_valid_0_d;
    logic          rsp_valid_1_q, rsp_valid_1_d;
    logic [DW-1:0] rsp_rdata_0_q, rsp_rdata_0_d;
    logic [DW-1:0] rsp_rdata_1_q, rsp_rdata_1_d;

    // ------------------------------------------------------------------
    // FSM and sweep counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            // Last word is written this cycle; traffic opens next cycle.
            if (&cnt_q) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StReset;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_done = (state_q == ST_RUN);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign arb_req = (state_q == ST_RUN) ? {req_valid_1, req_valid_0} : 2'b00;

    sram_rr_arb2 u_rr_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (accept),
        .gnt     (gnt)
    );

    // A grant is only issued to a valid requester, so grant implies accept.
    assign accept      = |gnt;
    assign req_ready_0 = gnt[0];
    assign req_ready_1 = gnt[1];

    // ------------------------------------------------------------------
    // SRAM port mux
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == ST_INIT) begin
            mem_we   = 1'b1;
            mem_addr = cnt_q;
        end else if (gnt[0]) begin
            mem_we    = req_we_0;
            mem_re    = ~req_we_0;
            mem_addr  = req_addr_0;
            mem_wdata = req_wdata_0;
        end else if (gnt[1]) begin
            mem_we    = req_we_1;
            mem_re    = ~req_we_1;
            mem_addr  = req_addr_1;
            mem_wdata = req_wdata_1;
        end
    end

    // ------------------------------------------------------------------
    // Read-return pipe: stage 1 remembers who read, stage 2 captures data
    // ------------------------------------------------------------------
    always_comb begin
        rd_pend_d     = mem_re;
        rd_port_d     = gnt[1] ? PORT1 : PORT0;
        rsp_valid_0_d = rd_pend_q && (rd_port_q == PORT0);
        rsp_valid_1_d = rd_pend_q && (rd_port_q == PORT1);
        rsp_rdata_0_d = rsp_valid_0_d ? mem_rdata : rsp_rdata_0_q;
        rsp_rdata_1_d = rsp_valid_1_d ? mem_rdata : rsp_rdata_1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q     <= 1'b0;
            rd_port_q     <= PORT0;
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            rsp_rdata_0_q <= '0;
            rsp_rdata_1_q <= '0;
        end else begin
            rd_pend_q     <= rd_pend_d;
            rd_port_q     <= rd_port_d;
            rsp_valid_0_q <= rsp_valid_0_d;
            rsp_valid_1_q <= rsp_valid_1_d;
            rsp_rdata_0_q <= rsp_rdata_0_d;
            rsp_rdata_1_q <= rsp_rdata_1_d;
        end
    end

    assign rsp_valid_0 = rsp_valid_0_q;
    assign rsp_valid_1 = rsp_valid_1_q;
    assign rsp_rdata_0 = rsp_rdata_0_q;
    assign rsp_rdata_1 = rsp_rdata_1_q;

endmodule
